// File: rtl/resv_station.sv
// Multi-entry reservation station: age-ordered compacting queue with operand
// wakeup from writeback broadcasts and oldest-ready select for two issue pipes.
module resv_station #(
  parameter int DEPTH   = 8,
  parameter int W_IDX   = 4,
  parameter int N_WB    = 2,
  parameter int W_req   = 2,
  parameter int W_uops  = 6,
  parameter int W_rx_a  = 5,
  parameter int W_rx_d  = 32,
  parameter int W_imm_d = 32,
  parameter int W_pc_d  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_req-1:0]         in_req,
  input  logic                     in_pip,
  input  logic [W_uops-1:0]        in_uops,
  input  logic [W_rx_a-1:0]        in_rd_a,
  input  logic                     in_rs_v,
  input  logic [W_rx_a-1:0]        in_rs_a,
  input  logic [W_rx_d-1:0]        in_rs_d,
  input  logic                     in_rt_v,
  input  logic [W_rx_a-1:0]        in_rt_a,
  input  logic [W_rx_d-1:0]        in_rt_d,
  input  logic [W_imm_d-1:0]       in_imm_d,
  input  logic [W_pc_d-1:0]        in_pc_d,
  input  logic [N_WB-1:0]          wb_valid,
  input  logic [N_WB*W_rx_a-1:0]   wb_a,
  input  logic [N_WB*W_rx_d-1:0]   wb_d,
  output logic                     is0_valid,
  input  logic                     is0_ready,
  output logic [W_uops-1:0]        is0_uops,
  output logic [W_rx_a-1:0]        is0_rd_a,
  output logic [W_rx_d-1:0]        is0_rs_d,
  output logic [W_rx_d-1:0]        is0_rt_d,
  output logic [W_imm_d-1:0]       is0_imm_d,
  output logic [W_pc_d-1:0]        is0_pc_d,
  output logic                     is1_valid,
  input  logic                     is1_ready,
  output logic [W_uops-1:0]        is1_uops,
  output logic [W_rx_a-1:0]        is1_rd_a,
  output logic [W_rx_d-1:0]        is1_rs_d,
  output logic [W_rx_d-1:0]        is1_rt_d,
  output logic [W_imm_d-1:0]       is1_imm_d,
  output logic [W_pc_d-1:0]        is1_pc_d,
  output logic [W_IDX-1:0]         count,
  output logic                     full,
  output logic                     empty
);

  typedef struct packed {
    logic [W_req-1:0]   req;
    logic               pip;
    logic [W_uops-1:0]  uops;
    logic [W_rx_a-1:0]  rd_a;
    logic               rs_v;
    logic [W_rx_a-1:0]  rs_a;
    logic [W_rx_d-1:0]  rs_d;
    logic               rt_v;
    logic [W_rx_a-1:0]  rt_a;
    logic [W_rx_d-1:0]  rt_d;
    logic [W_imm_d-1:0] imm_d;
    logic [W_pc_d-1:0]  pc_d;
  } entry_t;

  // Lowest port wins because a captured operand is never overwritten.
  function automatic entry_t wake(input entry_t e,
                                  input logic [N_WB-1:0] v,
                                  input logic [N_WB*W_rx_a-1:0] a,
                                  input logic [N_WB*W_rx_d-1:0] d);
    entry_t             r;
    logic [W_rx_a-1:0]  ak;
    logic [W_rx_d-1:0]  dk;
    r = e;
    for (int unsigned k = 0; k < N_WB; k++) begin
      ak = a[k*W_rx_a +: W_rx_a];
      dk = d[k*W_rx_d +: W_rx_d];
      if (v[k] && (ak != '0)) begin
        if (!r.rs_v && (r.rs_a == ak)) begin
          r.rs_v = 1'b1;
          r.rs_d = dk;
        end
        if (!r.rt_v && (r.rt_a == ak)) begin
          r.rt_v = 1'b1;
          r.rt_d = dk;
        end
      end
    end
    return r;
  endfunction

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [W_IDX-1:0] count_q, count_d;

  entry_t           in_e, ins_e;
  logic [DEPTH-1:0] vld, rdy, oh0, oh1, rm;
  logic             found0, found1, fire0, fire1, ins;
  logic [1:0]       nrm;
  logic [W_IDX-1:0] ins_slot;

  entry_t           wk    [DEPTH+2];
  logic [1:0]       below [DEPTH+2];
  logic [DEPTH+1:0] surv;
  logic [1:0]       acc;

  assign in_e = '{req: in_req, pip: in_pip, uops: in_uops, rd_a: in_rd_a,
                  rs_v: in_rs_v, rs_a: in_rs_a, rs_d: in_rs_d,
                  rt_v: in_rt_v, rt_a: in_rt_a, rt_d: in_rt_d,
                  imm_d: in_imm_d, pc_d: in_pc_d};

  always_comb begin
    vld    = '0;
    rdy    = '0;
    oh0    = '0;
    oh1    = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      vld[i] = (W_IDX'(i) < count_q);
      rdy[i] = vld[i] & (~ent_q[i].req[0] | ent_q[i].rs_v)
                      & (~ent_q[i].req[1] | ent_q[i].rt_v);
      if (rdy[i] && !ent_q[i].pip && !found0) begin
        oh0[i] = 1'b1;
        found0 = 1'b1;
      end
      if (rdy[i] && ent_q[i].pip && !found1) begin
        oh1[i] = 1'b1;
        found1 = 1'b1;
      end
    end
  end

  assign is0_valid = found0 & ~flush;
  assign is1_valid = found1 & ~flush;
  assign fire0     = is0_valid & is0_ready;
  assign fire1     = is1_valid & is1_ready;
  assign rm        = (oh0 & {DEPTH{fire0}}) | (oh1 & {DEPTH{fire1}});
  assign nrm       = 2'(fire0) + 2'(fire1);

  assign full     = (count_q == W_IDX'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = ~full;
  assign count    = count_q;
  assign ins      = in_valid & in_ready & ~flush;
  assign ins_slot = count_q - W_IDX'(nrm);
  assign count_d  = flush ? '0 : (count_q + W_IDX'(ins) - W_IDX'(nrm));

  always_comb begin
    is0_uops  = '0;
    is0_rd_a  = '0;
    is0_rs_d  = '0;
    is0_rt_d  = '0;
    is0_imm_d = '0;
    is0_pc_d  = '0;
    is1_uops  = '0;
    is1_rd_a  = '0;
    is1_rs_d  = '0;
    is1_rt_d  = '0;
    is1_imm_d = '0;
    is1_pc_d  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (oh0[i] && is0_valid) begin
        is0_uops  = ent_q[i].uops;
        is0_rd_a  = ent_q[i].rd_a;
        is0_rs_d  = ent_q[i].rs_d;
        is0_rt_d  = ent_q[i].rt_d;
        is0_imm_d = ent_q[i].imm_d;
        is0_pc_d  = ent_q[i].pc_d;
      end
      if (oh1[i] && is1_valid) begin
        is1_uops  = ent_q[i].uops;
        is1_rd_a  = ent_q[i].rd_a;
        is1_rs_d  = ent_q[i].rs_d;
        is1_rt_d  = ent_q[i].rt_d;
        is1_imm_d = ent_q[i].imm_d;
        is1_pc_d  = ent_q[i].pc_d;
      end
    end
  end

  // Slot j takes the survivor from j, j+1 or j+2 whose count of removed
  // entries below it is 0, 1 or 2; two zero-padded slots keep j+2 in range.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH + 2; i++) begin
      wk[i]    = '0;
      below[i] = '0;
    end
    surv = '0;
    acc  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wk[i]    = wake(ent_q[i], wb_valid, wb_a, wb_d);
      surv[i]  = vld[i] & ~rm[i];
      below[i] = acc;
      acc      = acc + 2'(rm[i]);
    end
    ins_e = wake(in_e, wb_valid, wb_a, wb_d);
    for (int unsigned j = 0; j < DEPTH; j++) begin
      ent_d[j] = ent_q[j];
      if (surv[j] && (below[j] == 2'd0)) begin
        ent_d[j] = wk[j];
      end else if (surv[j+1] && (below[j+1] == 2'd1)) begin
        ent_d[j] = wk[j+1];
      end else if (surv[j+2] && (below[j+2] == 2'd2)) begin
        ent_d[j] = wk[j+2];
      end else if (ins && (ins_slot == W_IDX'(j))) begin
        ent_d[j] = ins_e;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ent_q   <= '{default: '0};
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

endmodule

// File: tb/tb_resv_station.sv
// Bench for resv_station: directed scenarios plus randomized traffic checked
// against an age-ordered queue model of the station.
module tb_resv_station;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [1:0]  in_req;
  logic        in_pip, in_rs_v, in_rt_v;
  logic [5:0]  in_uops;
  logic [4:0]  in_rd_a, in_rs_a, in_rt_a;
  logic [31:0] in_rs_d, in_rt_d, in_imm_d, in_pc_d;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_a;
  logic [63:0] wb_d;
  logic        is0_valid, is0_ready, is1_valid, is1_ready;
  logic [5:0]  is0_uops, is1_uops;
  logic [4:0]  is0_rd_a, is1_rd_a;
  logic [31:0] is0_rs_d, is0_rt_d, is0_imm_d, is0_pc_d;
  logic [31:0] is1_rs_d, is1_rt_d, is1_imm_d, is1_pc_d;
  logic [3:0]  count;
  logic        full, empty;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  resv_station #(.DEPTH(8), .W_IDX(4), .N_WB(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_req(in_req), .in_pip(in_pip), .in_uops(in_uops), .in_rd_a(in_rd_a),
    .in_rs_v(in_rs_v), .in_rs_a(in_rs_a), .in_rs_d(in_rs_d),
    .in_rt_v(in_rt_v), .in_rt_a(in_rt_a), .in_rt_d(in_rt_d),
    .in_imm_d(in_imm_d), .in_pc_d(in_pc_d),
    .wb_valid(wb_valid), .wb_a(wb_a), .wb_d(wb_d),
    .is0_valid(is0_valid), .is0_ready(is0_ready), .is0_uops(is0_uops),
    .is0_rd_a(is0_rd_a), .is0_rs_d(is0_rs_d), .is0_rt_d(is0_rt_d),
    .is0_imm_d(is0_imm_d), .is0_pc_d(is0_pc_d),
    .is1_valid(is1_valid), .is1_ready(is1_ready), .is1_uops(is1_uops),
    .is1_rd_a(is1_rd_a), .is1_rs_d(is1_rs_d), .is1_rt_d(is1_rt_d),
    .is1_imm_d(is1_imm_d), .is1_pc_d(is1_pc_d),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    bit [1:0]  req;
    bit        pip;
    bit [5:0]  uops;
    bit [4:0]  rd_a;
    bit        rs_v;
    bit [4:0]  rs_a;
    bit [31:0] rs_d;
    bit        rt_v;
    bit [4:0]  rt_a;
    bit [31:0] rt_d;
    bit [31:0] imm;
    bit [31:0] pc;
  } uop_t;

  typedef logic [286:0] vec_t;

  uop_t q[$];

  function automatic uop_t mk(input bit pip, input bit [1:0] req, input bit [5:0] op);
    uop_t u;
    u.pip  = pip;
    u.req  = req;
    u.uops = op;
    u.rd_a = 5'($urandom);
    u.rs_v = 1'b0;
    u.rs_a = 5'd0;
    u.rs_d = $urandom;
    u.rt_v = 1'b0;
    u.rt_a = 5'd0;
    u.rt_d = $urandom;
    u.imm  = $urandom;
    u.pc   = $urandom;
    return u;
  endfunction

  task automatic put(input uop_t u);
    in_valid = 1'b1;
    in_req   = u.req;  in_pip  = u.pip;  in_uops = u.uops; in_rd_a = u.rd_a;
    in_rs_v  = u.rs_v; in_rs_a = u.rs_a; in_rs_d = u.rs_d;
    in_rt_v  = u.rt_v; in_rt_a = u.rt_a; in_rt_d = u.rt_d;
    in_imm_d = u.imm;  in_pc_d = u.pc;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0;
    wb_valid = '0;   wb_a = '0;  wb_d = '0;
    is0_ready = 1'b0; is1_ready = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_rdy(input uop_t u);
    return (!u.req[0] || u.rs_v) && (!u.req[1] || u.rt_v);
  endfunction

  function automatic int pick(input bit p);
    foreach (q[i]) if (is_rdy(q[i]) && q[i].pip == p) return i;
    return -1;
  endfunction

  function automatic uop_t wake(input uop_t u);
    bit [4:0] a;
    for (int k = 0; k < 2; k++) begin
      a = wb_a[k*5 +: 5];
      if (wb_valid[k] && a != 5'd0) begin
        if (!u.rs_v && u.rs_a == a) begin u.rs_v = 1'b1; u.rs_d = wb_d[k*32 +: 32]; end
        if (!u.rt_v && u.rt_a == a) begin u.rt_v = 1'b1; u.rt_d = wb_d[k*32 +: 32]; end
      end
    end
    return u;
  endfunction

  function automatic logic [139:0] pipe_exp(input bit p);
    int i = pick(p);
    if (i < 0 || flush) return '0;
    return {1'b1, q[i].uops, q[i].rd_a, q[i].rs_d, q[i].rt_d, q[i].imm, q[i].pc};
  endfunction

  function automatic vec_t exp_vec();
    int n = q.size();
    return {pipe_exp(1'b0), pipe_exp(1'b1), 4'(n), n == 8, n == 0, n < 8};
  endfunction

  function automatic vec_t obs_vec();
    return {is0_valid, is0_uops, is0_rd_a, is0_rs_d, is0_rt_d, is0_imm_d, is0_pc_d,
            is1_valid, is1_uops, is1_rd_a, is1_rs_d, is1_rt_d, is1_imm_d, is1_pc_d,
            count, full, empty, in_ready};
  endfunction

  function automatic void model_step();
    int   i0, i1;
    bit   f0, f1, ins;
    uop_t nu;
    if (flush) begin
      q.delete();
      return;
    end
    i0  = pick(1'b0);
    i1  = pick(1'b1);
    f0  = (i0 >= 0) && is0_ready;
    f1  = (i1 >= 0) && is1_ready;
    ins = in_valid && q.size() < 8;
    nu.req = in_req;   nu.pip = in_pip;   nu.uops = in_uops; nu.rd_a = in_rd_a;
    nu.rs_v = in_rs_v; nu.rs_a = in_rs_a; nu.rs_d = in_rs_d;
    nu.rt_v = in_rt_v; nu.rt_a = in_rt_a; nu.rt_d = in_rt_d;
    nu.imm = in_imm_d; nu.pc = in_pc_d;
    if (f0 && f1) begin
      q.delete(i0 > i1 ? i0 : i1);
      q.delete(i0 > i1 ? i1 : i0);
    end else if (f0) q.delete(i0);
    else if (f1) q.delete(i1);
    foreach (q[i]) q[i] = wake(q[i]);
    if (ins) q.push_back(wake(nu));
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    put(mk(1'b0, 2'b00, 6'd0));
    in_valid = 1'b0;
    #1;
    total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    total++; if ({is0_valid, is1_valid} !== 2'b00) $display("FAIL reset_valid got=%b exp=00", {is0_valid, is1_valid}); else passed++;
    total++; if ({is0_pc_d, is1_pc_d, is0_uops, is1_uops} !== '0) $display("FAIL reset_payload got=%h exp=0", {is0_pc_d, is1_pc_d, is0_uops, is1_uops}); else passed++;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_insert_issue();
    put(mk(1'b0, 2'b00, 6'd1));
    tick();
    put(mk(1'b1, 2'b00, 6'd2));
    #1;
    total++; if (count !== 4'd1) $display("FAIL ins_count1 got=%0d exp=1", count); else passed++;
    total++; if (is0_valid !== 1'b1 || is0_uops !== 6'd1) $display("FAIL ins_is0 got=%b/%0d exp=1/1", is0_valid, is0_uops); else passed++;
    total++; if (is1_valid !== 1'b0) $display("FAIL ins_is1_early got=%b exp=0", is1_valid); else passed++;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 4'd2) $display("FAIL ins_count2 got=%0d exp=2", count); else passed++;
    total++; if (is1_valid !== 1'b1 || is1_uops !== 6'd2) $display("FAIL ins_is1 got=%b/%0d exp=1/2", is1_valid, is1_uops); else passed++;
    is0_ready = 1'b1; is1_ready = 1'b1;
    tick();
    #1;
    total++; if (count !== 4'd0 || empty !== 1'b1) $display("FAIL ins_drain got=%0d/%b exp=0/1", count, empty); else passed++;
    idle();
  endtask

  task automatic test_wakeup();
    uop_t u = mk(1'b0, 2'b01, 6'd3);
    u.rs_a = 5'd5;
    put(u);
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (is0_valid !== 1'b0 || count !== 4'd1) $display("FAIL wake_wait got=%b/%0d exp=0/1", is0_valid, count); else passed++;
    wb_valid = 2'b10; wb_a = {5'd5, 5'd0}; wb_d = {32'hDEADBEEF, 32'h0};
    #1;
    total++; if (is0_valid !== 1'b0) $display("FAIL wake_no_bypass got=%b exp=0", is0_valid); else passed++;
    tick();
    wb_valid = '0;
    #1;
    total++; if (is0_valid !== 1'b1 || is0_rs_d !== 32'hDEADBEEF) $display("FAIL wake_data got=%b/%h exp=1/deadbeef", is0_valid, is0_rs_d); else passed++;
    is0_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_age_order();
    for (int i = 0; i < 8; i++) begin
      put(mk(1'b0, 2'b00, 6'(i + 16)));
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 4'd8) $display("FAIL age_full got=%b/%b/%0d exp=1/0/8", full, in_ready, count); else passed++;
    put(mk(1'b0, 2'b00, 6'd63));
    is0_ready = 1'b1;
    #1;
    total++; if (is0_uops !== 6'd16) $display("FAIL age_first got=%0d exp=16", is0_uops); else passed++;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1;
      total++; if (is0_uops !== 6'(16 + k) || count !== 4'(8 - k)) $display("FAIL age_order%0d got=%0d/%0d exp=%0d/%0d", k, is0_uops, count, 16 + k, 8 - k); else passed++;
      tick();
    end
    #1;
    total++; if (count !== 4'd0 || empty !== 1'b1) $display("FAIL age_empty got=%0d/%b exp=0/1", count, empty); else passed++;
    idle();
  endtask

  task automatic test_dual_issue();
    put(mk(1'b1, 2'b00, 6'd10)); tick();
    put(mk(1'b0, 2'b00, 6'd11)); tick();
    put(mk(1'b1, 2'b00, 6'd12)); tick();
    in_valid = 1'b0;
    #1;
    total++; if (is0_uops !== 6'd11 || is1_uops !== 6'd10 || count !== 4'd3) $display("FAIL dual_sel got=%0d/%0d/%0d exp=11/10/3", is0_uops, is1_uops, count); else passed++;
    is0_ready = 1'b1; is1_ready = 1'b1;
    tick();
    #1;
    total++; if (count !== 4'd1 || is1_valid !== 1'b1 || is1_uops !== 6'd12 || is0_valid !== 1'b0) $display("FAIL dual_compact got=%0d/%b/%0d/%b exp=1/1/12/0", count, is1_valid, is1_uops, is0_valid); else passed++;
    tick();
    idle();
  endtask

  task automatic test_edge_wakeup();
    uop_t u = mk(1'b0, 2'b01, 6'd20);
    put(u);
    tick();
    in_valid = 1'b0;
    wb_valid = 2'b11; wb_a = '0; wb_d = {32'h1234, 32'h5678};
    tick();
    wb_valid = '0;
    #1;
    total++; if (is0_valid !== 1'b0 || count !== 4'd1) $display("FAIL edge_addr0 got=%b/%0d exp=0/1", is0_valid, count); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    u = mk(1'b0, 2'b01, 6'd21);
    u.rs_a = 5'd7;
    put(u);
    tick();
    in_valid = 1'b0;
    wb_valid = 2'b11; wb_a = {5'd7, 5'd7}; wb_d = {32'h22, 32'h11};
    tick();
    wb_valid = '0;
    #1;
    total++; if (is0_valid !== 1'b1 || is0_rs_d !== 32'h11) $display("FAIL edge_priority got=%b/%h exp=1/11", is0_valid, is0_rs_d); else passed++;
    is0_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      put(mk(1'(i % 2), 2'b00, 6'(30 + i)));
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++; if (count !== 4'd5) $display("FAIL flush_pre got=%0d exp=5", count); else passed++;
    flush = 1'b1;
    put(mk(1'b0, 2'b00, 6'd40));
    is0_ready = 1'b1; is1_ready = 1'b1;
    #1;
    total++; if ({is0_valid, is1_valid} !== 2'b00 || is0_uops !== 6'd0) $display("FAIL flush_valid got=%b/%0d exp=00/0", {is0_valid, is1_valid}, is0_uops); else passed++;
    tick();
    idle();
    #1;
    total++; if (count !== 4'd0 || empty !== 1'b1 || is0_valid !== 1'b0) $display("FAIL flush_after got=%0d/%b/%b exp=0/1/0", count, empty, is0_valid); else passed++;
  endtask

  task automatic test_random();
    uop_t u;
    vec_t ov, ev;
    int   rp;
    for (int c = 0; c < 800; c++) begin
      rp = ((c / 100) % 2 == 0) ? 3 : 8;
      u = mk(1'($urandom), 2'($urandom), 6'($urandom));
      u.rs_v = 1'($urandom); u.rs_a = 5'($urandom_range(0, 7));
      u.rt_v = 1'($urandom); u.rt_a = 5'($urandom_range(0, 7));
      put(u);
      in_valid  = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      is0_ready = ($urandom_range(0, 9) < rp);
      is1_ready = ($urandom_range(0, 9) < rp);
      wb_valid  = 2'($urandom);
      wb_a      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb_d      = {32'($urandom), 32'($urandom)};
      #1;
      ov = obs_vec();
      ev = exp_vec();
      total++; if (ov !== ev) $display("FAIL rand_cycle%0d got=%h exp=%h", c, ov, ev); else passed++;
      tick();
    end
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      put(mk(1'(i % 2), 2'b00, 6'(50 + i)));
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 4'd0 || empty !== 1'b1 || in_ready !== 1'b1) $display("FAIL rstmid_count got=%0d/%b/%b exp=0/1/1", count, empty, in_ready); else passed++;
    total++; if ({is0_valid, is1_valid} !== 2'b00 || {is0_pc_d, is1_pc_d} !== '0) $display("FAIL rstmid_out got=%b/%h exp=00/0", {is0_valid, is1_valid}, {is0_pc_d, is1_pc_d}); else passed++;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_insert_issue();
    test_wakeup();
    test_age_order();
    test_dual_issue();
    test_edge_wakeup();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
